// File: rtl/vga_axil_if.sv
// Single-outstanding command bridge onto an AXI4-Lite master port.
// Optional response timeout enabled by defining VGA_AXIL_TIMEOUT_EN.
module vga_axil_if #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic                wvalid,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, DONE} state_t;

  state_t              state, state_d;
  logic                req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d, wdata_d;
  logic [1:0]          rsp_resp_d;
  logic [ADDR_W-1:0]   awaddr_d, araddr_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                aw_ok, w_ok, ar_ok;

`ifdef VGA_AXIL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`else
  // Parameter is only meaningful with the timeout build; keep it referenced.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  // A channel counts as handshaken if it already dropped valid or completes now.
  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid  || wready;
  assign ar_ok = !arvalid || arready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    awaddr_d    = awaddr;
    awvalid_d   = awvalid;
    wdata_d     = wdata;
    wvalid_d    = wvalid;
    wstrb_d     = wstrb;
    bready_d    = bready;
    araddr_d    = araddr;
    arvalid_d   = arvalid;
    rready_d    = rready;
`ifdef VGA_AXIL_TIMEOUT_EN
    cnt_d       = '0;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_write) begin
            state_d   = WR_REQ;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = {STRB_W{1'b1}};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d     = DONE;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
        end
      end
      RD_REQ: begin
        if (arvalid && arready) arvalid_d = 1'b0;
        if (rvalid && ar_ok) begin
          state_d     = DONE;
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef VGA_AXIL_TIMEOUT_EN
    // Abandon the transaction if no response arrives within the wait window.
    if (state == WR_REQ || state == WR_RESP || state == RD_REQ) begin
      cnt_d = cnt + CNT_W'(1);
      if (state_d != DONE && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = DONE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_resp_d  = RESP_SLVERR;
        rsp_rdata_d = '0;
      end
    end
`endif
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      wstrb     <= '0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
`ifdef VGA_AXIL_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
      awaddr    <= awaddr_d;
      awvalid   <= awvalid_d;
      wdata     <= wdata_d;
      wvalid    <= wvalid_d;
      wstrb     <= wstrb_d;
      bready    <= bready_d;
      araddr    <= araddr_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
`ifdef VGA_AXIL_TIMEOUT_EN
      cnt       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_vga_axil_if.sv
// Directed bench for vga_axil_if: write/read paths, stalls, error response,
// mid-transaction reset and the optional response timeout.
module tb_vga_axil_if;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 8;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic              awvalid, awready, wvalid, wready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready, arvalid, arready, rvalid, rready;

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;

  vga_axil_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wstrb(wstrb), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rsp_valid) rsp_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one command for a single cycle; it is accepted at the next edge.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      step();
      n++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  int n, base;

  initial begin
    arst_n = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    check("rst_regs", 64'({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp}), 64'd0);
    arst_n = 1'b1;
    step();
    check("req_ready_after_rst", 64'(req_ready), 64'd1);

    // Basic write: ready slave, OKAY response one cycle after handshakes.
    awready = 1; wready = 1;
    issue(1'b1, 32'h3, 32'h4);
    check("wr_valids", 64'({awvalid, wvalid}), 64'h3);
    check("wr_awaddr", 64'(awaddr), 64'h3);
    check("wr_wdata", 64'(wdata), 64'h4);
    check("wr_wstrb", 64'(wstrb), 64'hF);
    check("wr_busy", 64'(req_ready), 64'd0);
    step();
    check("wr_hs_drop", 64'({awvalid, wvalid, bready}), 64'h1);
    bvalid = 1; bresp = 2'd0;
    base = rsp_cnt;
    step();
    bvalid = 0;
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_resp", 64'(rsp_resp), 64'd0);
    check("wr_bready_low", 64'(bready), 64'd0);
    step();
    check("wr_one_pulse", 64'(rsp_cnt - base), 64'd1);
    check("wr_idle", 64'({req_ready, rsp_valid}), 64'h2);

    // Basic read: AR accepted at once, data one cycle later.
    arready = 1;
    issue(1'b0, 32'h3, 32'h0);
    check("rd_valids", 64'({arvalid, rready}), 64'h3);
    check("rd_araddr", 64'(araddr), 64'h3);
    step();
    check("rd_ar_drop", 64'({arvalid, rready}), 64'h1);
    rvalid = 1; rdata = 32'h4; rresp = 2'd0;
    step();
    rvalid = 0; rdata = 32'hFFFF_FFFF;
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rdata", 64'(rsp_rdata), 64'h4);
    check("rd_resp", 64'(rsp_resp), 64'd0);
    step();
    check("rd_hold", 64'(rsp_rdata), 64'h4);

    // Write with W stalled three cycles behind AW; extra request is ignored.
    awready = 1; wready = 0;
    issue(1'b1, 32'h20, 32'hA5A5_0001);
    step();
    check("st_aw_first", 64'({awvalid, wvalid, bready}), 64'h2);
    awready = 0;
    req_valid = 1; req_write = 0; req_addr = 32'h99;
    step();
    req_valid = 0;
    check("st_hold", 64'({awvalid, wvalid, bready, arvalid}), 64'h4);
    check("st_wdata", 64'(wdata), 64'hA5A5_0001);
    wready = 1;
    step();
    check("st_w_done", 64'({wvalid, bready}), 64'h1);
    bvalid = 1; bresp = 2'd0;
    wait_rsp(10, n);
    bvalid = 0;
    step();

    // Read with early rvalid (ignored before AR handshake), then SLVERR.
    arready = 0;
    issue(1'b0, 32'h40, 32'h0);
    rvalid = 1; rdata = 32'h111; rresp = 2'd0;
    step();
    check("er_early_r", 64'({rsp_valid, arvalid, rready}), 64'h3);
    arready = 1; rdata = 32'hDEAD; rresp = 2'd2;
    step();
    rvalid = 0; arready = 0;
    check("er_rsp", 64'({rsp_valid, rsp_resp}), 64'h6);
    check("er_rdata", 64'(rsp_rdata), 64'hDEAD);
    check("er_not_ready", 64'(req_ready), 64'd0);
    step();
    check("er_ready_again", 64'(req_ready), 64'd1);

    // Reset in WR_RESP aborts without a response; next write completes.
    awready = 1; wready = 1;
    issue(1'b1, 32'h8, 32'h8);
    step();
    check("ar_in_resp", 64'(bready), 64'd1);
    base = rsp_cnt;
    #2 arst_n = 1'b0;
    #1 check("ar_async_clr", 64'({bready, awvalid, wvalid, req_ready}), 64'h0);
    @(negedge clk);
    arst_n = 1'b1;
    step();
    step();
    check("ar_no_rsp", 64'(rsp_cnt - base), 64'd0);
    issue(1'b1, 32'h10, 32'h55);
    check("ar_next_aw", 64'(awaddr), 64'h10);
    bvalid = 1; bresp = 2'd0;
    wait_rsp(10, n);
    check("ar_next_resp", 64'(rsp_resp), 64'd0);
    bvalid = 0;
    step();

    // Response never arrives.
    issue(1'b1, 32'h14, 32'h66);
    base = rsp_cnt;
`ifdef VGA_AXIL_TIMEOUT_EN
    wait_rsp(20, n);
    check("to_cycles", 64'(n), 64'(TMO));
    check("to_resp", 64'(rsp_resp), 64'd2);
    check("to_rdata", 64'(rsp_rdata), 64'd0);
    check("to_drop", 64'({awvalid, wvalid, bready}), 64'd0);
    step();
    check("to_idle", 64'(req_ready), 64'd1);
`else
    repeat (100) step();
    check("to_none", 64'(rsp_cnt - base), 64'd0);
    check("to_wait", 64'({bready, req_ready}), 64'h2);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    step();
    check("to_recover", 64'(req_ready), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_axil_if.md
VGA_AXIL_IF -- requirements
Module: vga_axil_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI-Lite address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32: AXI-Lite data width in bits, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: response wait limit, used only when VGA_AXIL_TIMEOUT_EN is defined.
REQ-004 SHALL have these ports:
clk  in  1  sole clock, rising edge.
arst_n  in  1  asynchronous active-low reset.
req_valid  in  1  command request.
req_ready  out  1  command accepted when both req_valid and req_ready are high.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  command address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  read data; 0 for writes.
rsp_resp  out  2  response code: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
awaddr/awvalid  out  ADDR_W/1; awready  in  1.
wdata/wvalid  out  DATA_W/1; wstrb  out  DATA_W/8; wready  in  1.
bresp  in  2; bvalid  in  1; bready  out  1.
araddr/arvalid  out  ADDR_W/1; arready  in  1.
rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rready  out  1.

Function
REQ-005 SHALL implement an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ and DONE; all outputs SHALL be registered.
REQ-006 req_ready SHALL be high only in IDLE; a command accepted at edge N SHALL show its AXI valid signals from cycle N+1.
REQ-007 Write, IDLE->WR_REQ: awaddr=req_addr, wdata=req_wdata, wstrb all ones, awvalid=wvalid=1 asserted in the same cycle.
REQ-008 awvalid SHALL drop on the edge where awready=1, and wvalid SHALL drop on the edge where wready=1, independently; the handshakes may complete in either order or together.
REQ-009 Once both handshakes have completed, the FSM SHALL move to WR_RESP with bready=1, and SHALL capture bresp when bvalid=1, then go to DONE.
REQ-010 Read, IDLE->RD_REQ: araddr=req_addr, arvalid=1 and rready=1 asserted in the same cycle.
REQ-011 arvalid SHALL drop on arready; rready SHALL stay high until an rvalid is accepted, and rvalid is counted only in a cycle at or after the AR handshake.
REQ-012 On an accepted rvalid, the block SHALL capture rdata and rresp, then go to DONE.
REQ-013 DONE SHALL pulse rsp_valid for exactly one cycle with the captured rsp_rdata/rsp_resp, then return to IDLE; rsp_rdata SHALL hold its value until the next completion.
REQ-014 Non-OKAY responses SHALL pass to rsp_resp unchanged; the block SHALL NOT retry.
REQ-015 AXI valid signals SHALL NOT drop before their handshake, and addr/data SHALL stay stable while valid is high.
REQ-016 Only one outstanding transaction SHALL be allowed; req_valid outside IDLE SHALL be ignored.

Reset
REQ-017 When arst_n=0, the block SHALL asynchronously clear FSM to IDLE and clear all valid/ready outputs, rsp_valid, rsp_rdata, rsp_resp, awaddr, araddr, wdata and wstrb; req_ready SHALL be 1 from the first edge after release.
REQ-018 A reset during a transaction SHALL abort it, with no rsp_valid for the aborted command.

Configuration
REQ-019 With VGA_AXIL_TIMEOUT_EN defined: a counter SHALL clear on entry to WR_REQ/RD_REQ. If the response (bvalid or rvalid) is not accepted within TIMEOUT_CYCLES cycles, all AXI valid/ready outputs SHALL drop and DONE SHALL report rsp_resp=SLVERR with rsp_rdata=0.
REQ-020 Without VGA_AXIL_TIMEOUT_EN, no counter logic SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-021 Write addr 0x3 data 0x4, slave awready=wready=1 and bvalid=1/OKAY one cycle after AW/W handshake -> awvalid and wvalid rise in the same cycle, awaddr=0x3, wdata=0x4, wstrb=0xF; rsp_valid pulses once with rsp_resp=0.
REQ-022 Read addr 0x3, arready=1 immediately, rvalid the next cycle with rdata=0x4 and rresp=OKAY -> arvalid and rready rise together; rsp_rdata=0x4, rsp_resp=0.
REQ-023 Write with wready delayed 3 cycles after awready -> awvalid drops first, wvalid holds until wready, bready rises only after both handshakes.
REQ-024 Read returning rresp=SLVERR (2) -> rsp_resp=2 and req_ready high again one cycle later.
REQ-025 arst_n=0 during WR_RESP -> bready/awvalid/wvalid are 0 immediately, no rsp_valid, and the next write completes normally.
REQ-026 With VGA_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=8, bvalid never asserted -> rsp_valid with rsp_resp=2 after 8 wait cycles; without the macro, no rsp_valid after 100 cycles.
